mod_mul_pipe: RTL and testbench

Fully pipelined modular multiplier computing r = a·b mod Q with Barrett reduction, Q = 12289 by default, 14-bit coefficients. It sits in the NTT butterfly datapath directly upstream of the fixed-depth coefficient delay lines, which are sized to this block's latency. A sideband tag travels with each operand pair so downstream address logic stays aligned. One result per cycle, no backpressure; a global clock enable freezes the whole pipe.

---
 rtl/mod_mul_pipe.sv | 75 +++++++
 tb/tb_mod_mul_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mod_mul_pipe.sv
// Four-stage Barrett modular multiplier: r = a*b mod Q, with a sideband tag
// carried alongside. There is no backpressure; en freezes every stage register.
module mod_mul_pipe #(
  parameter int data_width = 14,
  parameter int Q          = 12289,
  parameter int tag_width  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  valid_in,
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  input  logic [tag_width-1:0]  tag_in,
  output logic                  valid_out,
  output logic [data_width-1:0] r,
  output logic [tag_width-1:0]  tag_out
);

  localparam int K                = 2 * data_width;
  localparam logic [63:0] M_INT   = (64'd1 << K) / 64'(Q);
  localparam int M_W              = $clog2(M_INT + 64'd1);
  localparam logic [M_W-1:0] M    = M_W'(M_INT);
  localparam int PW               = K + M_W;
  localparam int RW               = data_width + 2;
  localparam logic [RW-1:0] Q_R   = RW'(Q);
  localparam int LATENCY          = 4;

  // Handshake: valid_in qualifies a/b/tag_in on each enabled edge; valid_out
  // qualifies r/tag_out. There is no ready signal, so every op is accepted.

  logic [K-1:0]          p_s1;
  logic [RW-1:0]         p_s2;
  logic [M_W-1:0]        t_s2;
  logic [RW-1:0]         r0_s3;
  logic [data_width-1:0] r_s4;
  logic [LATENCY-1:0]    valid_sr;
  logic [tag_width-1:0]  tag_sr [LATENCY];

  // r0 < 3Q is guaranteed by the Barrett bound, so two conditional
  // subtractions are enough to land in [0, Q).
  function automatic logic [data_width-1:0] cond_sub2(input logic [RW-1:0] x);
    logic [RW-1:0] y;
    y = (x >= Q_R) ? x - Q_R : x;
    y = (y >= Q_R) ? y - Q_R : y;
    return data_width'(y);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      p_s1     <= '0;
      p_s2     <= '0;
      t_s2     <= '0;
      r0_s3    <= '0;
      r_s4     <= '0;
      valid_sr <= '0;
      for (int i = 0; i < LATENCY; i++) tag_sr[i] <= '0;
    end else if (en) begin
      p_s1     <= K'(a) * K'(b);
      t_s2     <= M_W'((PW'(p_s1) * PW'(M)) >> K);
      // Only the low RW bits of p matter: r0 is formed modulo 2^RW.
      p_s2     <= RW'(p_s1);
      r0_s3    <= p_s2 - RW'(t_s2) * Q_R;
      r_s4     <= cond_sub2(r0_s3);
      valid_sr <= {valid_sr[LATENCY-2:0], valid_in};
      tag_sr[0] <= tag_in;
      for (int i = 1; i < LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  assign valid_out = valid_sr[LATENCY-1];
  assign r         = r_s4;
  assign tag_out   = tag_sr[LATENCY-1];

endmodule

// File: tb/tb_mod_mul_pipe.sv
// Cycle-accurate bench for mod_mul_pipe: a queue of expected results keyed by
// the enabled-edge count at which each op must appear on the outputs.
module tb_mod_mul_pipe;

  localparam int QM = 12289;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid_in;
  logic [13:0] a;
  logic [13:0] b;
  logic [8:0]  tag_in;
  logic        valid_out;
  logic [13:0] r;
  logic [8:0]  tag_out;

  always #5 clk = ~clk;

  mod_mul_pipe dut (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .a(a), .b(b),
    .tag_in(tag_in), .valid_out(valid_out), .r(r), .tag_out(tag_out)
  );

  typedef struct packed {
    logic [31:0] due;
    logic [13:0] r;
    logic [8:0]  tag;
  } exp_t;

  exp_t  exp_q[$];
  int    en_cnt = 0;
  int    n_cmp  = 0;
  int    n_fail = 0;
  string phase  = "init";

  function automatic logic [13:0] rnd14();
    return 14'($urandom_range(0, 16383));
  endfunction

  function automatic logic [8:0] rnd9();
    return 9'($urandom_range(0, 511));
  endfunction

  // Drive one cycle, advance the reference model at the edge, then check.
  task automatic cycle(input logic v, input logic [13:0] aa, input logic [13:0] bb,
                       input logic [8:0] tg, input logic e, input logic rs);
    logic exp_v;
    exp_t head;
    valid_in = v; a = aa; b = bb; tag_in = tg; en = e; rst = rs;
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
    end else if (e) begin
      en_cnt++;
      while (exp_q.size() > 0 && int'(exp_q[0].due) < en_cnt) void'(exp_q.pop_front());
      if (v) exp_q.push_back('{due: 32'(en_cnt + 3),
                               r: 14'((int'(aa) * int'(bb)) % QM), tag: tg});
    end
    #1;
    exp_v = (exp_q.size() > 0) && (int'(exp_q[0].due) == en_cnt);
    n_cmp++;
    if (valid_out !== exp_v) begin
      n_fail++;
      $display("FAIL %s valid_out: got %b want %b (t=%0t)", phase, valid_out, exp_v, $time);
    end
    if (exp_v) begin
      head = exp_q[0];
      n_cmp++;
      if (r !== head.r) begin
        n_fail++;
        $display("FAIL %s r: got %0d want %0d (t=%0t)", phase, r, head.r, $time);
      end
      n_cmp++;
      if (tag_out !== head.tag) begin
        n_fail++;
        $display("FAIL %s tag_out: got %0d want %0d (t=%0t)", phase, tag_out, head.tag, $time);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, rnd14(), rnd14(), rnd9(), 1'b1, 1'b0);
  endtask

  task automatic check_zero_outputs();
    n_cmp++;
    if (r !== 14'd0) begin
      n_fail++;
      $display("FAIL %s r after reset: got %0d want 0", phase, r);
    end
    n_cmp++;
    if (tag_out !== 9'd0) begin
      n_fail++;
      $display("FAIL %s tag_out after reset: got %0d want 0", phase, tag_out);
    end
  endtask

  task automatic test_reset();
    phase = "reset";
    cycle(1'b1, rnd14(), rnd14(), rnd9(), 1'b1, 1'b1);
    cycle(1'b0, rnd14(), rnd14(), rnd9(), 1'b0, 1'b1);
    check_zero_outputs();
  endtask

  task automatic test_single();
    phase = "single";
    cycle(1'b1, 14'd3, 14'd4, 9'd5, 1'b1, 1'b0);
    idle(6);
  endtask

  task automatic test_wrap();
    phase = "wrap";
    cycle(1'b1, 14'd12288, 14'd12288, 9'd1, 1'b1, 1'b0);
    cycle(1'b1, 14'd12288, 14'd2,     9'd2, 1'b1, 1'b0);
    cycle(1'b1, 14'd16383, 14'd16383, 9'd3, 1'b1, 1'b0);
    cycle(1'b1, 14'd0,     rnd14(),   9'd4, 1'b1, 1'b0);
    cycle(1'b1, rnd14(),   14'd0,     9'd5, 1'b1, 1'b0);
    cycle(1'b1, 14'd1,     14'd12288, 9'd6, 1'b1, 1'b0);
    idle(5);
  endtask

  task automatic test_back_to_back();
    phase = "stream";
    for (int i = 0; i < 512; i++) cycle(1'b1, rnd14(), rnd14(), 9'(i), 1'b1, 1'b0);
    idle(5);
  endtask

  task automatic test_stall();
    phase = "stall";
    cycle(1'b1, rnd14(), rnd14(), 9'd10, 1'b1, 1'b0);
    cycle(1'b1, rnd14(), rnd14(), 9'd11, 1'b1, 1'b0);
    cycle(1'b1, rnd14(), rnd14(), 9'd12, 1'b1, 1'b0);
    cycle(1'b0, rnd14(), rnd14(), rnd9(), 1'b1, 1'b0);
    // First result is on the outputs now; freeze the pipe around it.
    cycle(1'b1, rnd14(), rnd14(), rnd9(), 1'b0, 1'b0);
    cycle(1'b1, rnd14(), rnd14(), rnd9(), 1'b0, 1'b0);
    idle(6);
  endtask

  task automatic test_reset_midflight();
    phase = "reset_mid";
    cycle(1'b1, rnd14(), rnd14(), 9'd20, 1'b1, 1'b0);
    cycle(1'b1, rnd14(), rnd14(), 9'd21, 1'b1, 1'b0);
    cycle(1'b1, rnd14(), rnd14(), 9'd22, 1'b1, 1'b0);
    cycle(1'b1, rnd14(), rnd14(), 9'd23, 1'b1, 1'b1);
    check_zero_outputs();
    cycle(1'b1, 14'd100, 14'd200, 9'd30, 1'b1, 1'b0);
    idle(8);
  endtask

  task automatic test_random_en();
    phase = "random_en";
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), rnd14(), rnd14(), rnd9(),
            1'($urandom_range(0, 3) != 0), 1'b0);
    idle(6);
  endtask

  task automatic test_sweep();
    phase = "sweep";
    for (int i = 0; i < 16384; i++) begin
      cycle(1'b1, 14'(i), 14'd10302, 9'(i), 1'b1, 1'b0);
      if (valid_out === 1'b1) begin
        n_cmp++;
        if (r >= 14'(QM)) begin
          n_fail++;
          $display("FAIL sweep range: got r=%0d want < %0d", r, QM);
        end
      end
    end
    idle(5);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid_in = 1'b0; a = '0; b = '0; tag_in = '0;
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random_en();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
